// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two one-entry holding buffers (ALU, load) share the register
// file write port via round-robin, with a registered write stage and RAW hazard flags.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              We,
    output logic [ADDR_W-1:0] W1,
    output logic [DATA_W-1:0] D1,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [CNT_W-1:0]  commit_count
);

    localparam logic LG_A = 1'b0;
    localparam logic LG_B = 1'b1;

    logic              hold_a_v;
    logic [ADDR_W-1:0] hold_a_addr;
    logic [DATA_W-1:0] hold_a_data;
    logic              hold_b_v;
    logic [ADDR_W-1:0] hold_b_addr;
    logic [DATA_W-1:0] hold_b_data;
    logic              last_grant;
    logic              grant_a;
    logic              grant_b;

    // On contention the source that did not win last time goes first.
    always_comb begin
        grant_a = hold_a_v && (!hold_b_v || (last_grant == LG_B));
        grant_b = hold_b_v && (!hold_a_v || (last_grant == LG_A));
    end

    assign a_ready = !hold_a_v || grant_a;
    assign b_ready = !hold_b_v || grant_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_a_v    <= 1'b0;
            hold_a_addr <= '0;
            hold_a_data <= '0;
            hold_b_v    <= 1'b0;
            hold_b_addr <= '0;
            hold_b_data <= '0;
        end else begin
            if (a_valid && a_ready) begin
                hold_a_v    <= 1'b1;
                hold_a_addr <= a_addr;
                hold_a_data <= a_data;
            end else if (grant_a) begin
                hold_a_v <= 1'b0;
            end
            if (b_valid && b_ready) begin
                hold_b_v    <= 1'b1;
                hold_b_addr <= b_addr;
                hold_b_data <= b_data;
            end else if (grant_b) begin
                hold_b_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            We           <= 1'b0;
            W1           <= '0;
            D1           <= '0;
            commit_count <= '0;
            last_grant   <= LG_B;
        end else begin
            We <= grant_a || grant_b;
            if (grant_a) begin
                W1         <= hold_a_addr;
                D1         <= hold_a_data;
                last_grant <= LG_A;
            end else if (grant_b) begin
                W1         <= hold_b_addr;
                D1         <= hold_b_data;
                last_grant <= LG_B;
            end
            if (grant_a || grant_b) begin
                commit_count <= commit_count + 1'b1;
            end
        end
    end

    // Anything accepted but not yet written into the register file is a hazard.
    always_comb begin
        hazard1 = (hold_a_v && (hold_a_addr == rd_addr1)) ||
                  (hold_b_v && (hold_b_addr == rd_addr1)) ||
                  (We && (W1 == rd_addr1));
        hazard2 = (hold_a_v && (hold_a_addr == rd_addr2)) ||
                  (hold_b_v && (hold_b_addr == rd_addr2)) ||
                  (We && (W1 == rd_addr2));
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, directed sequences
// and randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [2:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        We;
    logic [2:0]  W1;
    logic [31:0] D1;
    logic [2:0]  rd_addr1, rd_addr2;
    logic        hazard1, hazard2;
    logic [15:0] commit_count;

    regfile_wb_arbiter #(.ADDR_W(3), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .We(We), .W1(W1), .D1(D1),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hazard1(hazard1), .hazard2(hazard2),
        .commit_count(commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The register file this block feeds.
    logic [31:0] rf [8];
    always @(posedge clk) if (We) rf[W1] <= D1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: pending writes per source, plus the write-stage outputs.
    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         qa[$];
    wr_t         qb[$];
    bit          m_b_last;
    bit          m_we;
    logic [2:0]  m_w1;
    logic [31:0] m_d1;
    logic [15:0] m_cnt;

    function automatic bit model_hz(input logic [2:0] rd);
        bit h = 0;
        foreach (qa[i]) if (qa[i].addr == rd) h = 1;
        foreach (qb[i]) if (qb[i].addr == rd) h = 1;
        if (m_we && m_w1 == rd) h = 1;
        return h;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_b_last = 1;
        m_we  = 0;
        m_w1  = '0;
        m_d1  = '0;
        m_cnt = '0;
    endtask

    // Inputs already driven; check outputs, advance one edge, update model.
    task automatic step();
        bit ga, gb, acc_a, acc_b;
        wr_t na, nb, w;
        #1;
        ga = (qa.size() != 0) && ((qb.size() == 0) || m_b_last);
        gb = (qb.size() != 0) && ((qa.size() == 0) || !m_b_last);
        chk("a_ready", a_ready, (qa.size() == 0) || ga);
        chk("b_ready", b_ready, (qb.size() == 0) || gb);
        chk("We", We, m_we);
        chk("W1", W1, m_w1);
        chk("D1", D1, m_d1);
        chk("hazard1", hazard1, model_hz(rd_addr1));
        chk("hazard2", hazard2, model_hz(rd_addr2));
        chk("commit_count", commit_count, m_cnt);
        acc_a = a_valid && ((qa.size() == 0) || ga);
        acc_b = b_valid && ((qb.size() == 0) || gb);
        na.addr = a_addr; na.data = a_data;
        nb.addr = b_addr; nb.data = b_data;
        @(posedge clk);
        #1;
        if (ga) begin
            w = qa.pop_front();
            m_we = 1; m_w1 = w.addr; m_d1 = w.data; m_b_last = 0;
        end else if (gb) begin
            w = qb.pop_front();
            m_we = 1; m_w1 = w.addr; m_d1 = w.data; m_b_last = 1;
        end else begin
            m_we = 0;
        end
        if (ga || gb) m_cnt = m_cnt + 16'd1;
        if (acc_a) qa.push_back(na);
        if (acc_b) qb.push_back(nb);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        model_reset();
        #2;
        chk("rst_We", We, 1'b0);
        chk("rst_W1", W1, 3'd0);
        chk("rst_D1", D1, 32'd0);
        chk("rst_cnt", commit_count, 16'd0);
        chk("rst_a_ready", a_ready, 1'b1);
        chk("rst_b_ready", b_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit          av; logic [2:0] aa; logic [31:0] ad;
        bit          bv; logic [2:0] ba; logic [31:0] bd;
        logic [2:0]  r1; logic [2:0] r2;
        bit          ear; bit ebr; bit ewe;
        logic [2:0]  ew1; logic [31:0] ed1;
        bit          eh1; bit eh2;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vt[8];

    initial begin
        int we_cycles;
        logic [31:0] saved0, saved2;

        // simultaneous A/B after reset, then a held-write hazard on addr 7
        vt[0] = '{1,3'd1,32'h11111111, 1,3'd2,32'h22222222, 3'd1,3'd2, 1,1,0, 3'd0,32'h0,        0,0, 16'd0};
        vt[1] = '{0,3'd0,32'h0,        0,3'd0,32'h0,        3'd1,3'd2, 1,0,0, 3'd0,32'h0,        1,1, 16'd0};
        vt[2] = '{0,3'd0,32'h0,        0,3'd0,32'h0,        3'd1,3'd2, 1,1,1, 3'd1,32'h11111111, 1,1, 16'd1};
        vt[3] = '{0,3'd0,32'h0,        0,3'd0,32'h0,        3'd1,3'd2, 1,1,1, 3'd2,32'h22222222, 0,1, 16'd2};
        vt[4] = '{1,3'd7,32'h77777777, 0,3'd0,32'h0,        3'd7,3'd2, 1,1,0, 3'd2,32'h22222222, 0,0, 16'd2};
        vt[5] = '{0,3'd0,32'h0,        0,3'd0,32'h0,        3'd7,3'd2, 1,1,0, 3'd2,32'h22222222, 1,0, 16'd2};
        vt[6] = '{0,3'd0,32'h0,        0,3'd0,32'h0,        3'd7,3'd2, 1,1,1, 3'd7,32'h77777777, 1,0, 16'd3};
        vt[7] = '{0,3'd0,32'h0,        0,3'd0,32'h0,        3'd7,3'd2, 1,1,0, 3'd7,32'h77777777, 0,0, 16'd3};

        rst = 1'b1;
        a_valid = 0; b_valid = 0;
        a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
        rd_addr1 = 0; rd_addr2 = 0;
        #1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            a_valid = vt[i].av; a_addr = vt[i].aa; a_data = vt[i].ad;
            b_valid = vt[i].bv; b_addr = vt[i].ba; b_data = vt[i].bd;
            rd_addr1 = vt[i].r1; rd_addr2 = vt[i].r2;
            #1;
            chk($sformatf("vec%0d_a_ready", i), a_ready, vt[i].ear);
            chk($sformatf("vec%0d_b_ready", i), b_ready, vt[i].ebr);
            chk($sformatf("vec%0d_We", i), We, vt[i].ewe);
            chk($sformatf("vec%0d_W1", i), W1, vt[i].ew1);
            chk($sformatf("vec%0d_D1", i), D1, vt[i].ed1);
            chk($sformatf("vec%0d_hazard1", i), hazard1, vt[i].eh1);
            chk($sformatf("vec%0d_hazard2", i), hazard2, vt[i].eh2);
            chk($sformatf("vec%0d_cnt", i), commit_count, vt[i].ecnt);
            @(posedge clk);
            #1;
        end
        chk("vec_rf1", rf[1], 32'h11111111);
        chk("vec_rf2", rf[2], 32'h22222222);
        chk("vec_rf7", rf[7], 32'h77777777);

        // single A write
        do_reset();
        a_valid = 1; a_addr = 3'd3; a_data = 32'hDEADBEEF;
        rd_addr1 = 3'd3; rd_addr2 = 3'd0;
        step();
        a_valid = 0;
        we_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (We) begin
                we_cycles++;
                chk("single_W1", W1, 3'd3);
                chk("single_D1", D1, 32'hDEADBEEF);
            end
        end
        chk("single_we_cycles", we_cycles, 1);
        chk("single_rf3", rf[3], 32'hDEADBEEF);
        chk("single_cnt", commit_count, 16'd1);

        // both sources streaming: strict alternation, one write per cycle
        do_reset();
        a_valid = 1; a_addr = 3'd4; b_valid = 1; b_addr = 3'd5;
        a_data = $urandom; b_data = $urandom;
        step();
        for (int i = 0; i < 16; i++) begin
            a_data = $urandom; b_data = $urandom;
            step();
            chk($sformatf("stream%0d_We", i), We, 1'b1);
            chk($sformatf("stream%0d_W1", i), W1, (i % 2 == 0) ? 3'd4 : 3'd5);
        end
        chk("stream_cnt", commit_count, 16'd16);
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 4; i++) step();
        chk("stream_drain_cnt", commit_count, 16'd18);

        // same-address collision: B lands last
        do_reset();
        a_valid = 1; a_addr = 3'd6; a_data = 32'hAAAAAAAA;
        b_valid = 1; b_addr = 3'd6; b_data = 32'h55555555;
        step();
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 4; i++) step();
        chk("collide_rf6", rf[6], 32'h55555555);
        chk("collide_cnt", commit_count, 16'd2);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            a_valid = ($urandom_range(0, 9) < 6);
            b_valid = ($urandom_range(0, 9) < 6);
            a_addr = 3'($urandom); b_addr = 3'($urandom);
            a_data = $urandom; b_data = $urandom;
            rd_addr1 = 3'($urandom); rd_addr2 = 3'($urandom);
            step();
        end
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 4; i++) step();

        // reset while B is held and a write is in flight
        do_reset();
        a_valid = 1; a_addr = 3'd0; a_data = 32'hCAFEF00D;
        b_valid = 1; b_addr = 3'd2; b_data = 32'h12345678;
        rd_addr1 = 3'd2; rd_addr2 = 3'd0;
        step();
        a_valid = 0; b_valid = 0;
        step();
        #1;
        chk("midrst_pre_We", We, 1'b1);
        chk("midrst_pre_hazard1", hazard1, 1'b1);
        saved0 = rf[0];
        saved2 = rf[2];
        do_reset();
        for (int i = 0; i < 3; i++) step();
        chk("midrst_rf2", rf[2], saved2);
        chk("midrst_rf0", rf[0], saved0);
        chk("midrst_cnt", commit_count, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
